// File: rtl/mmu_req_arbiter.sv
// Arbitrates L1I and L1D line requests onto the single l1mmu port, one transaction at a time.
// Optional round-robin tie-breaking is enabled by defining MMU_ARB_ROUND_ROBIN_EN.
module mmu_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ic_req_read,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_req_read,
    input  logic              dc_req_write,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              mmu_req_read,
    output logic              mmu_req_write,
    output logic [ADDR_W-1:0] mmu_req_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                req_read_q, req_read_d;
    logic                req_write_q, req_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
    logic                ic_done_q, ic_done_d;
    logic                dc_done_q, dc_done_d;
    logic                busy_q, busy_d;

    logic ic_req;
    logic dc_req;
    logic grant_dc;

    assign ic_req = ic_req_read;
    assign dc_req = dc_req_read | dc_req_write;

`ifdef MMU_ARB_ROUND_ROBIN_EN
    // last_grant_q: 1 = D was granted last; a tie goes to the port opposite to it.
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_dc = dc_req & (~ic_req | ~last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (ic_req || dc_req)) begin
            last_grant_d = grant_dc;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant_dc = dc_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    if (grant_dc) begin
                        state_d     = SERVE_D;
                        addr_d      = dc_req_addr;
                        wdata_d     = dc_write_data;
                        // A simultaneous read+write from L1D is a writeback.
                        req_write_d = dc_req_write;
                        req_read_d  = ~dc_req_write;
                    end else begin
                        state_d     = SERVE_I;
                        addr_d      = ic_req_addr;
                        wdata_d     = '0;
                        req_write_d = 1'b0;
                        req_read_d  = 1'b1;
                    end
                end
            end
            SERVE_I: begin
                if (mmu_done) begin
                    state_d     = RESP;
                    ic_rdata_d  = mmu_read_data;
                    ic_done_d   = 1'b1;
                    req_read_d  = 1'b0;
                    req_write_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (mmu_done) begin
                    state_d     = RESP;
                    dc_rdata_d  = mmu_read_data;
                    dc_done_d   = 1'b1;
                    req_read_d  = 1'b0;
                    req_write_d = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
            busy_q      <= busy_d;
        end
    end

    assign mmu_req_read   = req_read_q;
    assign mmu_req_write  = req_write_q;
    assign mmu_req_addr   = addr_q;
    assign mmu_write_data = wdata_q;
    assign ic_done        = ic_done_q;
    assign dc_done        = dc_done_q;
    assign ic_read_data   = ic_rdata_q;
    assign dc_read_data   = dc_rdata_q;
    assign busy           = busy_q;

endmodule

// File: doc/mmu_req_arbiter.md
Name: mmu_req_arbiter

Overview:
- Two-port request arbiter between the L1 instruction cache, the L1 data cache and the single l1mmu port.
- Replaces the ad-hoc serve_ic / dmmu_pending muxing with a registered, one-transaction-at-a-time grant FSM.
- Latches the winning request and holds it stable to l1mmu until mmu_done.
- Routes the completion and the 256-bit line back to the owning cache only.

Parameters:
ADDR_W, 32, request address width
LINE_W, 256, cache line width for read/write data

Ports:
sys_clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
ic_req_read  input  1  L1I line fill request, held until ic_done
ic_req_addr  input  ADDR_W  L1I line address
ic_done  output  1  one-cycle completion pulse to L1I
ic_read_data  output  LINE_W  line returned to L1I, valid while ic_done=1
dc_req_read  input  1  L1D line fill request, held until dc_done
dc_req_write  input  1  L1D writeback request, held until dc_done
dc_req_addr  input  ADDR_W  L1D line address
dc_write_data  input  LINE_W  L1D writeback line
dc_done  output  1  one-cycle completion pulse to L1D
dc_read_data  output  LINE_W  line returned to L1D, valid while dc_done=1
mmu_req_read  output  1  read request to l1mmu
mmu_req_write  output  1  write request to l1mmu
mmu_req_addr  output  ADDR_W  latched address to l1mmu
mmu_write_data  output  LINE_W  latched writeback line to l1mmu
mmu_done  input  1  l1mmu completion pulse
mmu_read_data  input  LINE_W  l1mmu read line, valid with mmu_done
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (sys_clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - all outputs 0; data outputs all-zero.
  - FSM = IDLE; latched addr/data/type = 0; last_grant = D.
- FSM states: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE:
  - Sample requests at each edge.
  - No request: stay in IDLE.
  - Request present: pick a winner, latch {addr, write_data, read/write} from that port into internal registers, go to SERVE_I or SERVE_D.
- Fixed priority (default): D wins over I when both request.
- dc_req_read and dc_req_write both high: treat as write; read is ignored.
- SERVE_x:
  - Drive mmu_req_read/mmu_req_write/mmu_req_addr/mmu_write_data from the latched registers only; they stay stable even if requester inputs change.
  - Exactly one of mmu_req_read/mmu_req_write is high.
  - On mmu_done=1: capture mmu_read_data into the owner's response register, drop mmu_req_* the next cycle, go to RESP.
- RESP:
  - Assert the owner's done for exactly one cycle with the captured line on its read_data; the other port's done stays 0.
  - Go to IDLE unconditionally.
  - The requester deasserts its request in the cycle it sees done. Because requests are sampled only in IDLE, a request still high during RESP is never re-granted.
- Latency:
  - Request seen high at edge N in IDLE → mmu_req_* high from cycle N+1.
  - mmu_done at edge M → owner done at cycle M+1.
  - Minimum turnaround (IDLE→IDLE) is 3 cycles plus l1mmu latency.
- The non-owning port's request stays pending with no effect until the next IDLE sample.
- mmu_done while in IDLE or RESP: ignored, no done pulse, no state change.
- Write transactions: the done pulse is still issued; the owner's read_data is don't-care but driven with the captured mmu_read_data.
- read_data outputs hold their value outside done pulses (no clearing required); benches check them only while done=1.
- Reset mid-transaction (rst_n low in any state): next edge forces IDLE and all reset values. The in-flight request is abandoned; l1mmu shares rst_n and resets with it. No done pulse is issued.
- busy = (state != IDLE); registered.

Optional Feature:
- Macro: MMU_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous I and D request in IDLE, grant the port opposite to last_grant.
  - last_grant updates on each grant; its reset value D means I wins the first tie.
  - A lone request is granted regardless of last_grant.
- Undefined: fixed D-over-I priority as above; last_grant register is not synthesized.

Test Plan:
- Lone I read:
  - Stimulus: ic_req_read=1, addr 0x0040_0020; l1mmu done 4 cycles after request; mmu_read_data=0xA5…A5.
  - Required: mmu_req_read high from cycle+1 with addr 0x0040_0020; ic_done one cycle after mmu_done with 0xA5…A5; dc_done stays 0.
- Lone D write:
  - Stimulus: dc_req_write=1, addr 0x1001_0000, dc_write_data=0x1234…; dcache changes dc_write_data during SERVE_D.
  - Required: mmu_req_write=1 and mmu_write_data=0x1234… held stable throughout SERVE_D; dc_done single pulse.
- Simultaneous, fixed priority:
  - Stimulus: ic_req_read and dc_req_read rise on the same edge.
  - Required: D served first; I served in the following transaction; exactly one done pulse per port, in order D then I.
- Stray mmu_done: pulse mmu_done while in IDLE → no ic_done/dc_done, state stays IDLE, busy=0.
- Reset mid-transaction: rst_n=0 for one cycle during SERVE_I → next cycle busy=0, mmu_req_read=0, ic_done never pulses for that request.
- Round-robin (MMU_ARB_ROUND_ROBIN_EN):
  - Stimulus: both ports request continuously for 4 transactions.
  - Required: grant order I, D, I, D.
